adpcm_nibble_uart_tx: RTL and testbench
=======================================

// Module: adpcm_nibble_uart_tx
// PURPOSE
//  Downstream stage of the CIC/ADPCM compressor. Captures each 4-bit ADPCM code (enc_pcm qualified by
//  enc_valid) and packs two codes per byte: first code -> [3:0], second -> [7:4]. Completed bytes are
//  buffered in a small FIFO and sent off-chip as 8N1 UART frames on a single tx pin.
// PARAMETERS
//  CLK_DIV     16  clk cycles per UART bit; legal range >= 2
//  FIFO_DEPTH  4   byte FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1  single clock; all logic rising-edge, no other clocks
//  rst         in   1  synchronous, active-high reset
//  enable      in   1  block enable; low = stop accepting codes
//  enc_valid   in   1  compressor outValid, synchronous to clk; may stay high for many cycles
//  enc_pcm     in   4  ADPCM code; sampled on the cycle enc_valid rises
//  tx          out  1  UART serial output; idle high
//  busy        out  1  high while a frame is on tx or the FIFO is non-empty
//  overflow    out  1  sticky; set when a completed byte is dropped because the FIFO is full
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: tx=1, busy=0, overflow=0, fifo_level=0. Nibble-half flag cleared, FIFO emptied, FSM -> IDLE.
//   Reset mid-frame aborts the frame immediately (tx=1 on the next cycle).
//  Capture: registered copy valid_q. One code is accepted per rising edge (enc_valid & ~valid_q & enable).
//   A level held high counts once. valid_q resets to 1, so a valid already high at reset exit is ignored.
//  Packing: half=0 -> store code in lo, half<=1. half=1 -> push {code,lo}, half<=0.
//  enable low: half and lo cleared (a pending odd nibble is discarded); FIFO contents and any frame in
//   flight still drain normally.
//  FIFO: push and pop in the same cycle when full -> both succeed, level unchanged.
//   Push when full with no pop -> byte dropped, overflow<=1 (held until rst).
//   fifo_level updates the cycle after the push or pop.
//  UART FSM: IDLE -> START -> DATA -> STOP -> IDLE (or START when the FIFO is non-empty at end of STOP).
//   IDLE: if FIFO non-empty, pop into shreg and go to START.
//   START: tx=0 for CLK_DIV cycles.
//   DATA: 8 bits, LSB first, CLK_DIV cycles each; bit counter 0..7.
//   STOP: tx=1 for CLK_DIV cycles.
//   Back-to-back frames have no extra idle bit. Frame length = 10*CLK_DIV cycles.
//  Latency: edge sampled at clk edge N (second nibble) -> byte in FIFO at N+1 -> tx low from N+3 when
//   the FSM is idle.
//  Baud counter: counts 0..CLK_DIV-1 and wraps; resets to 0 on every state change.
//  busy = (state!=IDLE) | (fifo_level!=0).
// STRUCTURE
//  adpcm_pkg: typedef enum {IDLE,START,DATA,STOP} uart_state_t; NIBBLE_W=4; BYTE_W=8.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/level, registered read data.
//  Top holds edge detect, nibble packer, baud counter and UART FSM.
// TESTING
//  1 Codes 0x3 then 0xA, one pulse each, CLK_DIV=4 -> frame: start, bits of 0xA3 LSB-first (1,1,0,0,0,1,0,1),
//    stop; tx low at N+3.
//  2 enc_valid held high 50 cycles with enc_pcm=0x5 -> exactly one code accepted; half=1; no frame sent.
//  3 Six bytes pushed faster than frames drain, FIFO_DEPTH=4 -> first 5 sent in order (1 in shreg + 4 in
//    FIFO); 6th dropped; overflow=1 and stays 1 until rst.
//  4 Code 0x7, then enable=0 one cycle, then enable=1, codes 0x1, 0x2 -> one byte 0x21 sent; 0x7 discarded.
//  5 rst asserted mid-DATA bit 4 -> tx=1, busy=0, fifo_level=0 next cycle; no partial frame resumes.
//  6 Two bytes queued -> second start bit immediately follows first stop bit; total 20*CLK_DIV cycles low-to-idle.

Source files
------------

// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared types and widths for the ADPCM nibble packer / UART transmitter
package adpcm_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int NIBBLE_W = 4;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/adpcm_nibble_uart_tx_if.sv
// adpcm_nibble_uart_tx_if: code input and UART status bundle between compressor side and transmitter
interface adpcm_nibble_uart_tx_if
    import adpcm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) ();
    logic                        enable;
    logic                        enc_valid;
    logic [NIBBLE_W-1:0]         enc_pcm;
    logic                        tx;
    logic                        busy;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    modport master (output enable, enc_valid, enc_pcm, input tx, busy, overflow, fifo_level);
    modport slave (input enable, enc_valid, enc_pcm, output tx, busy, overflow, fifo_level);
endinterface

// File: rtl/adpcm_nibble_uart_tx_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with registered read data; a push while full only lands if a pop frees a slot
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;
    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign dout  = dout_q;
    assign level = level_q;
    // Qualify requests, advance pointers and occupancy, fetch the head on pop
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        dout_d  = do_pop ? mem_q[rd_q] : dout_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
    // Pointer, occupancy and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            dout_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: rtl/adpcm_nibble_uart_tx.sv
// adpcm_nibble_uart_tx: packs ADPCM nibble pairs into bytes, queues them and sends 8N1 UART frames
module adpcm_nibble_uart_tx
    import adpcm_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    adpcm_nibble_uart_tx_if.slave  bus
);
    localparam int BW = $clog2(CLK_DIV);
    logic                        valid_q, valid_d, half_q, half_d, push_q, push_d;
    logic [NIBBLE_W-1:0]         lo_q, lo_d;
    logic [BYTE_W-1:0]           byte_q, byte_d, shreg_q, shreg_d, fifo_dout;
    uart_state_t                 state_q, state_d;
    logic [BW-1:0]               baud_q, baud_d;
    logic [2:0]                  bit_q, bit_d;
    logic                        tx_q, tx_d, overflow_q, overflow_d;
    logic                        accept, pop, baud_end, full, empty;
    logic [$clog2(FIFO_DEPTH):0] level;
    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push_q), .pop(pop), .din(byte_q),
        .dout(fifo_dout), .full(full), .empty(empty), .level(level)
    );
    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != IDLE) | ~empty;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level;
    // Rising-edge capture and nibble pairing; a completed byte is pushed one cycle later
    always_comb begin
        accept     = bus.enc_valid & ~valid_q & bus.enable;
        valid_d    = bus.enc_valid;
        half_d     = bus.enable & (half_q ^ accept);
        lo_d       = ~bus.enable ? '0 : (accept & ~half_q) ? bus.enc_pcm : lo_q;
        push_d     = accept & half_q;
        byte_d     = {bus.enc_pcm, lo_q};
        overflow_d = overflow_q | (push_q & full & ~pop);
    end
    // UART sequencing: start bit, eight data bits LSB first, stop bit, chaining straight into the next frame
    always_comb begin
        baud_end = baud_q == BW'(CLK_DIV - 1);
        state_d  = state_q;
        pop      = 1'b0;
        bit_d    = bit_q;
        shreg_d  = (state_q == START) ? fifo_dout : shreg_q;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = START;
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_end) begin
                shreg_d = shreg_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (baud_end) begin
                pop     = ~empty;
                state_d = empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
        baud_d = (state_d != state_q || baud_end) ? '0 : baud_q + BW'(1);
        tx_d   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[0] : 1'b1;
    end
    // State registers; valid_q starts high so a level already present at reset exit is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b1;
            half_q     <= 1'b0;
            lo_q       <= '0;
            push_q     <= 1'b0;
            byte_q     <= '0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            half_q     <= half_d;
            lo_q       <= lo_d;
            push_q     <= push_d;
            byte_q     <= byte_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_adpcm_nibble_uart_tx.sv
// tb_adpcm_nibble_uart_tx: directed and randomized checks against a frame-schedule model of the transmitter
module tb_adpcm_nibble_uart_tx;
    localparam int D = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    adpcm_nibble_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();
    adpcm_nibble_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {logic [7:0] b; int push; int pop;} ent_t;
    ent_t mq[$];
    int ecnt = 0;
    int npass = 0;
    int ntot = 0;
    int last_pop, ovf_edge;
    bit chk_on = 1'b0;
    logic m_prev, m_half;
    logic [3:0] m_lo;

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    endtask

    // A byte reaching the FIFO at edge pe is popped when the line frees up, or dropped if the FIFO is full with no pop
    function automatic void mpush(input logic [7:0] b, input int pe);
        int occ;
        bit popnow;
        int p;
        occ = 0;
        popnow = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].push < pe && mq[i].pop >= pe) occ++;
            if (mq[i].pop == pe) popnow = 1'b1;
        end
        if (occ == DEPTH && !popnow) begin
            if (ovf_edge < 0) ovf_edge = pe;
        end else begin
            p = (pe + 1 > last_pop + 10 * D) ? pe + 1 : last_pop + 10 * D;
            last_pop = p;
            mq.push_back('{b, pe, p});
        end
    endfunction

    // Reference model: edge-counted capture, packing and frame scheduling
    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            mq.delete();
            m_prev = 1'b1;
            m_half = 1'b0;
            m_lo = '0;
            last_pop = -1000000;
            ovf_edge = -1;
            chk_on = 1'b1;
        end else begin
            if (!bus.enable) begin
                m_half = 1'b0;
                m_lo = '0;
            end else if (bus.enc_valid && !m_prev) begin
                if (!m_half) begin
                    m_lo = bus.enc_pcm;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    mpush({bus.enc_pcm, m_lo}, ecnt + 1);
                end
            end
            m_prev = bus.enc_valid;
            while (mq.size() > 0 && mq[0].pop + 10 * D < ecnt) void'(mq.pop_front());
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin : cmp
        int lvl, bz, et, k;
        if (chk_on) begin
            lvl = 0;
            bz = 0;
            et = 1;
            foreach (mq[i]) begin
                if (mq[i].push <= ecnt && mq[i].pop > ecnt) lvl++;
                if (mq[i].pop <= ecnt && ecnt < mq[i].pop + 10 * D) bz = 1;
                if (ecnt >= mq[i].pop + 1 && ecnt < mq[i].pop + 1 + 10 * D) begin
                    k = (ecnt - mq[i].pop - 1) / D;
                    et = (k == 0) ? 0 : (k == 9) ? 1 : int'(mq[i].b[k-1]);
                end
            end
            check("tx", int'(bus.tx), et);
            check("busy", int'(bus.busy), (bz != 0 || lvl > 0) ? 1 : 0);
            check("fifo_level", int'(bus.fifo_level), lvl);
            check("overflow", int'(bus.overflow), (ovf_edge >= 0 && ecnt >= ovf_edge) ? 1 : 0);
        end
    end

    logic [7:0] rx_bytes[$];
    int rx_start[$];
    int rx_end[$];
    int rx_t;
    bit rx_on = 1'b0;
    logic [7:0] rx_sh;
    // Independent UART receiver sampling mid-bit
    always @(negedge clk) begin : mon
        if (rst) rx_on = 1'b0;
        else if (!rx_on) begin
            if (bus.tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t = 0;
                rx_start.push_back(ecnt);
            end
        end else begin
            rx_t++;
            if (rx_t % D == D / 2 && rx_t >= D && rx_t < 9 * D) rx_sh[rx_t/D-1] = bus.tx;
            if (rx_t == 10 * D - 1) begin
                rx_on = 1'b0;
                rx_bytes.push_back(rx_sh);
                rx_end.push_back(ecnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [3:0] c, output int e);
        bus.enc_valid = 1'b1;
        bus.enc_pcm = c;
        e = ecnt + 1;
        cyc(1);
        bus.enc_valid = 1'b0;
        cyc(1);
    endtask

    task automatic at_neg(input int n);
        @(negedge clk);
        while (ecnt < n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        cyc(2);
        while (bus.busy && k < 2000) begin
            cyc(1);
            k++;
        end
        check("idle_within_bound", int'(bus.busy), 0);
        cyc(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
        rx_end.delete();
    endtask

    initial begin
        int n, s, rate;
        logic [7:0] v;
        bus.enable = 1'b1;
        bus.enc_valid = 1'b0;
        bus.enc_pcm = '0;
        cyc(4);
        check("reset_tx", int'(bus.tx), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_overflow", int'(bus.overflow), 0);
        check("reset_level", int'(bus.fifo_level), 0);
        rst = 1'b0;
        cyc(2);
        // 0x3 then 0xA -> 0xA3, start bit three edges after the second capture
        pulse(4'h3, n);
        pulse(4'hA, n);
        at_neg(n + 1);
        check("t1_level", int'(bus.fifo_level), 1);
        at_neg(n + 2);
        check("t1_tx_before", int'(bus.tx), 1);
        at_neg(n + 3);
        check("t1_start", int'(bus.tx), 0);
        for (int k = 0; k < 8; k++) begin
            at_neg(n + 3 + D * (k + 1) + D / 2);
            v[k] = bus.tx;
        end
        check("t1_byte", int'(v), 8'hA3);
        at_neg(n + 3 + 9 * D + 1);
        check("t1_stop", int'(bus.tx), 1);
        wait_idle();
        check("t1_rx_count", rx_bytes.size(), 1);
        check("t1_rx_byte", int'(rx_bytes[0]), 8'hA3);
        // held level counts once; next code pairs with it
        clear_rx();
        bus.enc_pcm = 4'h5;
        bus.enc_valid = 1'b1;
        cyc(50);
        bus.enc_valid = 1'b0;
        cyc(5);
        check("t2_busy", int'(bus.busy), 0);
        check("t2_level", int'(bus.fifo_level), 0);
        pulse(4'h6, n);
        wait_idle();
        check("t2_rx_count", rx_bytes.size(), 1);
        check("t2_rx_byte", int'(rx_bytes[0]), 8'h65);
        // six bytes faster than the line drains
        clear_rx();
        for (int i = 0; i < 12; i++) pulse(4'(i), n);
        wait_idle();
        check("t3_rx_count", rx_bytes.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_rx_byte", int'(rx_bytes[i]), ((2 * i + 1) << 4) | (2 * i));
        check("t3_overflow", int'(bus.overflow), 1);
        cyc(50);
        check("t3_overflow_sticky", int'(bus.overflow), 1);
        // enable drop discards the pending nibble
        do_reset();
        check("t4_overflow_cleared", int'(bus.overflow), 0);
        clear_rx();
        pulse(4'h7, n);
        bus.enable = 1'b0;
        cyc(1);
        bus.enable = 1'b1;
        pulse(4'h1, n);
        pulse(4'h2, n);
        wait_idle();
        check("t4_rx_count", rx_bytes.size(), 1);
        check("t4_rx_byte", int'(rx_bytes[0]), 8'h21);
        // reset in the middle of data bit 4 with a second byte queued
        clear_rx();
        pulse(4'hC, n);
        pulse(4'h3, n);
        s = n + 3;
        pulse(4'h1, n);
        pulse(4'h2, n);
        at_neg(s + 21);
        check("t5_busy_before", int'(bus.busy), 1);
        check("t5_level_before", int'(bus.fifo_level), 1);
        check("t5_bit4", int'(bus.tx), 1);
        cyc(1);
        rst = 1'b1;
        at_neg(s + 23);
        check("t5_tx", int'(bus.tx), 1);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_level", int'(bus.fifo_level), 0);
        cyc(1);
        rst = 1'b0;
        clear_rx();
        cyc(30 * D);
        check("t5_no_resume", rx_start.size(), 0);
        check("t5_tx_idle", int'(bus.tx), 1);
        // back-to-back frames
        clear_rx();
        pulse(4'h1, n);
        pulse(4'h2, n);
        pulse(4'h3, n);
        pulse(4'h4, n);
        wait_idle();
        check("t6_rx_count", rx_bytes.size(), 2);
        check("t6_byte0", int'(rx_bytes[0]), 8'h21);
        check("t6_byte1", int'(rx_bytes[1]), 8'h43);
        check("t6_gap", rx_start[1] - rx_start[0], 10 * D);
        check("t6_total", rx_end[1] - rx_start[0] + 1, 20 * D);
        // randomized traffic with varying code rate, enable drops and rare resets
        rate = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = $urandom_range(1, 8);
            bus.enc_valid = ($urandom_range(0, rate) == 0);
            bus.enc_pcm = 4'($urandom);
            bus.enable = ($urandom_range(0, 40) != 0);
            rst = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        rst = 1'b0;
        bus.enc_valid = 1'b0;
        bus.enable = 1'b1;
        wait_idle();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
